frame_write_master: RTL and testbench

Writes one camera frame of pixels into a linear SDRAM region [wrAddr, maxWr) through an Avalon-style write port. Sits directly downstream of the capture controller: it samples that controller's wrAddr/maxWr at start of frame and returns the almostDoneWr pulse that advances the controller's state. A small FIFO absorbs memory back-pressure, because the camera cannot be stalled.

---
 rtl/frame_write_master_if.sv | 25 ++
 rtl/frame_write_master.sv | 123 ++++++++++++
 tb/tb_frame_write_master.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/frame_write_master_if.sv
// Pixel stream in / Avalon-style write port out for frame_write_master.
interface frame_write_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 23
);
  logic              pix_valid;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_data;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_write;
  logic              mem_waitrequest;

  // Writer side: consumes pixels, issues memory writes.
  modport master (
    input  pix_valid, pix_sof, pix_data, mem_waitrequest,
    output mem_address, mem_writedata, mem_write
  );

  // Camera + memory side.
  modport slave (
    output pix_valid, pix_sof, pix_data, mem_waitrequest,
    input  mem_address, mem_writedata, mem_write
  );
endinterface

// File: rtl/frame_write_master.sv
// Writes one camera frame into [wrAddr, maxWr) through a small pixel FIFO.
module frame_write_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 23,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMOST_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [ADDR_W-1:0] maxWr,
  frame_write_master_if.master bus,
  output logic              almostDoneWr,
  output logic              busy,
  output logic              overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] GAP  = ADDR_W'(ALMOST_GAP);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [PTR_W:0]    FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] base, len, acc_cnt, wr_cnt;
  logic [ADDR_W-1:0] start_len, fire_idx;
  logic              fired;
  logic              start, push, pop, drop, mem_wr, hit;
  logic              fifo_empty, fifo_full, last_pix;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL);
  assign start_len  = maxWr - wrAddr;
  assign start      = bus.pix_valid & bus.pix_sof & (maxWr > wrAddr);
  assign last_pix   = ((acc_cnt + ONE) == len);
  // Short regions (len < gap) report on their final write instead.
  assign fire_idx   = (len < GAP) ? (len - ONE) : (len - GAP);
  assign hit        = pop & ~fired & (wr_cnt == fire_idx);

  assign bus.mem_write     = mem_wr;
  assign bus.mem_address   = base + wr_cnt;
  assign bus.mem_writedata = fifo[rd_ptr];
  assign busy              = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, FIFO push/pop/drop and memory request.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    drop     = 1'b0;
    mem_wr   = (state != IDLE) & ~fifo_empty;
    pop      = mem_wr & ~bus.mem_waitrequest;
    unique case (state)
      IDLE: begin
        if (start) begin
          push     = 1'b1;
          state_nx = (start_len == ONE) ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (bus.pix_valid) begin
          // A pop in the same cycle frees a slot, so full+pop still pushes.
          if (fifo_full & ~pop) drop = 1'b1;
          else                  push = 1'b1;
          if (last_pix) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty || (count == (PTR_W+1)'(1) && pop)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.pix_data;
  end

  // Pointers, counters, frame latch, pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      base         <= '0;
      len          <= '0;
      acc_cnt      <= '0;
      wr_cnt       <= '0;
      fired        <= 1'b0;
      overflow     <= 1'b0;
      almostDoneWr <= 1'b0;
    end else begin
      almostDoneWr <= hit;
      if (hit)  fired    <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wr_cnt <= wr_cnt + ONE;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (state == IDLE && start) begin
        base    <= wrAddr;
        len     <= start_len;
        acc_cnt <= ONE;
        wr_cnt  <= '0;
        fired   <= 1'b0;
      end else if (state == FILL && bus.pix_valid) begin
        acc_cnt <= acc_cnt + ONE;
      end
    end
  end
endmodule

// File: tb/tb_frame_write_master.sv
// Randomized/directed bench for frame_write_master against a queue-based frame model.
module tb_frame_write_master;
  localparam int DEPTH = 8;
  localparam logic [22:0] GAP = 23'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] wrAddr, maxWr;
  logic        almostDoneWr, busy, overflow;

  frame_write_master_if #(.DATA_W(16), .ADDR_W(23)) bus ();

  frame_write_master #(
    .DATA_W(16), .ADDR_W(23), .FIFO_DEPTH(DEPTH), .ALMOST_GAP(1)
  ) dut (
    .clk(clk), .reset(reset), .wrAddr(wrAddr), .maxWr(maxWr),
    .bus(bus), .almostDoneWr(almostDoneWr), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model: an in-progress frame, its pending words and counters.
  logic        m_active, m_taking, m_ovf, m_pulse, m_fired;
  logic [22:0] m_base, m_len, m_acc, m_wr;
  logic [15:0] mq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic s, input logic [15:0] d,
                            input logic w, input logic rst_n);
    logic        acc;
    logic [22:0] tgt;
    if (!rst_n) begin
      m_active = 0; m_taking = 0; m_ovf = 0; m_pulse = 0; m_fired = 0;
      m_base = 0; m_len = 0; m_acc = 0; m_wr = 0;
      mq.delete();
      return;
    end
    acc = m_active && (mq.size() > 0) && !w;
    m_pulse = 0;
    if (acc) begin
      tgt = (m_len < GAP) ? m_len - 23'd1 : m_len - GAP;
      if (!m_fired && m_wr == tgt) begin m_pulse = 1; m_fired = 1; end
      void'(mq.pop_front());
      m_wr = m_wr + 23'd1;
    end
    if (!m_active) begin
      if (v && s && maxWr > wrAddr) begin
        m_base = wrAddr; m_len = maxWr - wrAddr; m_acc = 23'd1; m_wr = 0;
        m_fired = 0; mq.push_back(d); m_active = 1; m_taking = (m_len != 23'd1);
      end
    end else if (m_taking && v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1;
      m_acc = m_acc + 23'd1;
      if (m_acc == m_len) m_taking = 0;
    end
    if (m_active && !m_taking && mq.size() == 0) m_active = 0;
  endtask

  task automatic step(input logic v, input logic s, input logic [15:0] d,
                      input logic w, input logic rst_n);
    logic exp_write;
    bus.pix_valid = v; bus.pix_sof = s; bus.pix_data = d;
    bus.mem_waitrequest = w; reset = rst_n;
    @(negedge clk);
    exp_write = m_active && (mq.size() > 0);
    check("mem_write", 32'(bus.mem_write), 32'(exp_write));
    check("mem_address", 32'(bus.mem_address), 32'(m_base + m_wr));
    if (exp_write) check("mem_writedata", 32'(bus.mem_writedata), 32'(mq[0]));
    check("busy", 32'(busy), 32'(m_active));
    check("almostDoneWr", 32'(almostDoneWr), 32'(m_pulse));
    check("overflow", 32'(overflow), 32'(m_ovf));
    @(posedge clk);
    model_edge(v, s, d, w, rst_n);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 1);
  endtask

  task automatic drain(input logic randwait);
    for (int i = 0; i < 200 && m_active; i++)
      step(0, 0, 16'h0, randwait ? ($urandom_range(0, 2) == 0) : 1'b0, 1);
  endtask

  task automatic frame(input logic [22:0] a, input logic [22:0] m, input int n);
    wrAddr = a; maxWr = m;
    step(1, 1, 16'($urandom), 0, 1);
    for (int i = 1; i < n; i++) step(1, 0, 16'($urandom), 0, 1);
  endtask

  initial begin
    bus.pix_valid = 0; bus.pix_sof = 0; bus.pix_data = '0; bus.mem_waitrequest = 0;
    wrAddr = '0; maxWr = '0; reset = 0;
    repeat (2) @(posedge clk);
    #1;
    model_edge(0, 0, 16'h0, 0, 0);
    step(0, 0, 16'h0, 0, 0);          // reset values
    idle(1);

    // Basic frame 100..103, then region swap to the second buffer.
    frame(23'd100, 23'd104, 4);
    idle(4);
    frame(23'd307200, 23'd614400, 3);
    step(0, 0, 16'h0, 0, 0);          // abort huge frame
    idle(1);

    // Back-pressure on the second write for three cycles.
    wrAddr = 23'd100; maxWr = 23'd104;
    step(1, 1, 16'hA000, 0, 1);
    step(1, 0, 16'hA001, 0, 1);
    step(1, 0, 16'hA002, 1, 1);
    step(1, 0, 16'hA003, 1, 1);
    step(0, 0, 16'h0, 1, 1);
    drain(0);
    idle(2);

    // Zero-length and one-length regions.
    wrAddr = 23'd50; maxWr = 23'd50;
    step(1, 1, 16'h5555, 0, 1);
    idle(3);
    maxWr = 23'd51;
    step(1, 1, 16'h5151, 0, 1);
    idle(4);

    // sof in the middle of a frame is ordinary data.
    wrAddr = 23'd100; maxWr = 23'd104;
    step(1, 1, 16'hB000, 0, 1);
    step(1, 0, 16'hB001, 0, 1);
    step(1, 1, 16'hB002, 0, 1);
    step(1, 0, 16'hB003, 0, 1);
    idle(4);

    // Reset at pixel 2, then restart at the new base.
    step(1, 1, 16'hC000, 0, 1);
    step(1, 0, 16'hC001, 0, 1);
    step(1, 0, 16'hC002, 0, 0);
    idle(2);
    frame(23'd120, 23'd123, 3);
    drain(0);

    // Back-to-back: sof in the first idle cycle after the previous frame.
    frame(23'd200, 23'd203, 3);
    drain(0);
    frame(23'd210, 23'd212, 2);
    drain(0);
    idle(1);

    // Overflow: 12 pixels while memory stalls; 8 kept, overflow sticky.
    frame(23'd0, 23'd0, 0);
    wrAddr = 23'd100; maxWr = 23'd112;
    step(1, 1, 16'($urandom), 1, 1);
    for (int i = 1; i < 12; i++) step(1, 0, 16'($urandom), 1, 1);
    drain(0);
    idle(3);
    step(0, 0, 16'h0, 0, 0);
    idle(1);

    // Random frames with random stalls, gaps, stray sofs and region changes.
    for (int f = 0; f < 25; f++) begin
      wrAddr = 23'($urandom_range(0, 5000));
      maxWr  = wrAddr + 23'($urandom_range(1, 14));
      step(1, 1, 16'($urandom), $urandom_range(0, 2) == 0, 1);
      for (int i = 0; i < 300 && m_taking; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          wrAddr = 23'($urandom_range(0, 5000));
          maxWr  = wrAddr + 23'($urandom_range(0, 14));
        end
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             16'($urandom), $urandom_range(0, 2) == 0, 1);
      end
      drain(1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        step($urandom_range(0, 1) == 1, 0, 16'($urandom), 0, 1);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
